// File: rtl/regfile_writeback_unit_if.sv
// Producer result channels (ALU, memory) and the register-file write port
// of regfile_writeback_unit.
interface regfile_writeback_unit_if #(
    parameter int AW = 4,
    parameter int DW = 16
);
    logic          alu_valid;
    logic          alu_ready;
    logic [AW-1:0] alu_addr;
    logic [DW-1:0] alu_data;
    logic          mem_valid;
    logic          mem_ready;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_data;
    logic          write_enable;
    logic [AW-1:0] write_addr;
    logic [DW-1:0] write_data;

    modport master (
        output alu_valid, alu_addr, alu_data,
        output mem_valid, mem_addr, mem_data,
        input  alu_ready, mem_ready,
        input  write_enable, write_addr, write_data
    );

    modport slave (
        input  alu_valid, alu_addr, alu_data,
        input  mem_valid, mem_addr, mem_data,
        output alu_ready, mem_ready,
        output write_enable, write_addr, write_data
    );
endinterface

// File: rtl/regfile_writeback_unit.sv
// Register-file writeback: two-producer arbiter, result FIFO, registered write
// port and busy scoreboard. Define WB_FORWARD_EN to enable pending-result forwarding.
module regfile_writeback_unit #(
    parameter int DEPTH = 4,
    parameter int AW    = 4,
    parameter int DW    = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    regfile_writeback_unit_if.slave bus,
    input  logic                   wb_hold,
    input  logic                   issue_valid,
    input  logic [AW-1:0]          issue_addr,
    output logic [15:0]            busy,
    input  logic [AW-1:0]          fwd_addr,
    output logic                   fwd_hit,
    output logic [DW-1:0]          fwd_data
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [AW-1:0] addr_mem_q [DEPTH];
    logic [AW-1:0] addr_mem_d [DEPTH];
    logic [DW-1:0] data_mem_q [DEPTH];
    logic [DW-1:0] data_mem_d [DEPTH];
    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic          write_enable_q, write_enable_d;
    logic [AW-1:0] write_addr_q, write_addr_d;
    logic [DW-1:0] write_data_q, write_data_d;
    logic [15:0]   busy_q, busy_d;

    logic          pop;
    logic          space;
    logic          take_mem;
    logic          take_alu;
    logic          push;
    logic [AW-1:0] push_addr;
    logic [DW-1:0] push_data;

    // Memory results have fixed priority over ALU results.
    always_comb begin
        pop           = !wb_hold && (count_q != '0);
        space         = (count_q < CW'(DEPTH)) || pop;
        bus.mem_ready = space;
        bus.alu_ready = space && !bus.mem_valid;
        take_mem      = bus.mem_valid && space;
        take_alu      = bus.alu_valid && space && !bus.mem_valid;
        push          = take_mem || take_alu;
        push_addr     = take_mem ? bus.mem_addr : bus.alu_addr;
        push_data     = take_mem ? bus.mem_data : bus.alu_data;
    end

    always_comb begin
        addr_mem_d = addr_mem_q;
        data_mem_d = data_mem_q;
        head_d     = head_q;
        tail_d     = tail_q;
        count_d    = count_q;
        if (push) begin
            addr_mem_d[tail_q] = push_addr;
            data_mem_d[tail_q] = push_data;
            tail_d             = tail_q + 1'b1;
        end
        if (pop) begin
            head_d = head_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (pop && !push) begin
            count_d = count_q - 1'b1;
        end
    end

    always_comb begin
        write_enable_d = pop;
        write_addr_d   = pop ? addr_mem_q[head_q] : write_addr_q;
        write_data_d   = pop ? data_mem_q[head_q] : write_data_q;
        // A new issue to the register being committed keeps it busy.
        busy_d = busy_q;
        if (write_enable_q) begin
            busy_d[write_addr_q] = 1'b0;
        end
        if (issue_valid) begin
            busy_d[issue_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q         <= '0;
            tail_q         <= '0;
            count_q        <= '0;
            write_enable_q <= 1'b0;
            write_addr_q   <= '0;
            write_data_q   <= '0;
            busy_q         <= '0;
        end else begin
            head_q         <= head_d;
            tail_q         <= tail_d;
            count_q        <= count_d;
            write_enable_q <= write_enable_d;
            write_addr_q   <= write_addr_d;
            write_data_q   <= write_data_d;
            busy_q         <= busy_d;
        end
    end

    always_ff @(posedge clk) begin
        addr_mem_q <= addr_mem_d;
        data_mem_q <= data_mem_d;
    end

    assign bus.write_enable = write_enable_q;
    assign bus.write_addr   = write_addr_q;
    assign bus.write_data   = write_data_q;
    assign busy             = busy_q;

`ifdef WB_FORWARD_EN
    logic [PW-1:0] fwd_idx;

    // Scans oldest-to-youngest after the output stage; the last match wins,
    // which equals a youngest-first search.
    always_comb begin
        fwd_idx  = '0;
        fwd_hit  = write_enable_q && (write_addr_q == fwd_addr);
        fwd_data = fwd_hit ? write_data_q : '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            fwd_idx = head_q + PW'(i);
            if ((CW'(i) < count_q) && (addr_mem_q[fwd_idx] == fwd_addr)) begin
                fwd_hit  = 1'b1;
                fwd_data = data_mem_q[fwd_idx];
            end
        end
    end
`else
    logic unused_fwd_addr;

    assign unused_fwd_addr = ^fwd_addr;
    assign fwd_hit         = 1'b0;
    assign fwd_data        = '0;
`endif
endmodule

// File: tb/tb_regfile_writeback_unit.sv
// Self-checking bench for regfile_writeback_unit: directed vector table,
// corner-case sequences and randomized traffic against a queue-based model.
module tb_regfile_writeback_unit;
    localparam int DEPTH = 4;
    localparam int AW    = 4;
    localparam int DW    = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          wb_hold;
    logic          issue_valid;
    logic [AW-1:0] issue_addr;
    logic [15:0]   busy;
    logic [AW-1:0] fwd_addr;
    logic          fwd_hit;
    logic [DW-1:0] fwd_data;

    always #5 clk = ~clk;

    regfile_writeback_unit_if #(.AW(AW), .DW(DW)) bus ();

    regfile_writeback_unit #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .wb_hold     (wb_hold),
        .issue_valid (issue_valid),
        .issue_addr  (issue_addr),
        .busy        (busy),
        .fwd_addr    (fwd_addr),
        .fwd_hit     (fwd_hit),
        .fwd_data    (fwd_data)
    );

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct packed {
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } ent_t;

    ent_t          mq[$];
    logic          m_we;
    logic [AW-1:0] m_wa;
    logic [DW-1:0] m_wd;
    logic [15:0]   m_busy;

    typedef struct {
        bit            av; logic [AW-1:0] aa; logic [DW-1:0] ad;
        bit            mv; logic [AW-1:0] ma; logic [DW-1:0] md;
        bit            iv; logic [AW-1:0] ia;
        bit            x_ar, x_mr, x_we;
        logic [AW-1:0] x_wa; logic [DW-1:0] x_wd; logic [15:0] x_busy;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(bit av, logic [AW-1:0] aa, logic [DW-1:0] ad,
                                bit mv, logic [AW-1:0] ma, logic [DW-1:0] md,
                                bit iv, logic [AW-1:0] ia, bit x_ar, bit x_mr,
                                bit x_we, logic [AW-1:0] x_wa, logic [DW-1:0] x_wd,
                                logic [15:0] x_busy);
        vec_t v;
        v.av = av; v.aa = aa; v.ad = ad; v.mv = mv; v.ma = ma; v.md = md;
        v.iv = iv; v.ia = ia; v.x_ar = x_ar; v.x_mr = x_mr; v.x_we = x_we;
        v.x_wa = x_wa; v.x_wd = x_wd; v.x_busy = x_busy;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic set_in(input bit av, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                          input bit mv, input logic [AW-1:0] ma, input logic [DW-1:0] md,
                          input bit iv, input logic [AW-1:0] ia);
        bus.alu_valid = av; bus.alu_addr = aa; bus.alu_data = ad;
        bus.mem_valid = mv; bus.mem_addr = ma; bus.mem_data = md;
        issue_valid   = iv; issue_addr   = ia;
    endtask

    task automatic idle_in();
        set_in(1'b0, '0, '0, 1'b0, '0, '0, 1'b0, '0);
    endtask

    // Combinational checks for the current inputs against the model.
    task automatic pre_check();
        bit            pop, space, ex_hit;
        logic [DW-1:0] ex_fd;
        #1;
        pop   = !wb_hold && mq.size() != 0;
        space = mq.size() < DEPTH || pop;
        ex_hit = 1'b0;
        ex_fd  = '0;
`ifdef WB_FORWARD_EN
        for (int i = int'(mq.size()) - 1; i >= 0; i--) begin
            if (!ex_hit && mq[i].a == fwd_addr) begin
                ex_hit = 1'b1;
                ex_fd  = mq[i].d;
            end
        end
        if (!ex_hit && m_we && m_wa == fwd_addr) begin
            ex_hit = 1'b1;
            ex_fd  = m_wd;
        end
`endif
        if (!reset) begin
            chk("mem_ready", bus.mem_ready, space);
            chk("alu_ready", bus.alu_ready, space && !bus.mem_valid);
            chk("fwd_hit", fwd_hit, ex_hit);
            chk("fwd_data", fwd_data, ex_fd);
        end
    endtask

    // Clock edge: advance the model, then check registered outputs.
    task automatic tick();
        bit          pop, space;
        logic [15:0] nb;
        ent_t        e;
        pop   = !wb_hold && mq.size() != 0;
        space = mq.size() < DEPTH || pop;
        @(posedge clk);
        if (reset) begin
            mq.delete();
            m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0;
        end else begin
            nb = m_busy;
            if (m_we) nb[m_wa] = 1'b0;
            if (issue_valid) nb[issue_addr] = 1'b1;
            m_busy = nb;
            m_we = pop;
            if (pop) begin
                e = mq.pop_front();
                m_wa = e.a;
                m_wd = e.d;
            end
            if (bus.mem_valid && space) begin
                mq.push_back('{a: bus.mem_addr, d: bus.mem_data});
            end else if (bus.alu_valid && space) begin
                mq.push_back('{a: bus.alu_addr, d: bus.alu_data});
            end
        end
        #1;
        chk("write_enable", bus.write_enable, m_we);
        chk("write_addr", bus.write_addr, m_wa);
        chk("write_data", bus.write_data, m_wd);
        chk("busy", busy, m_busy);
    endtask

    task automatic apply();
        pre_check();
        tick();
    endtask

    initial begin
        m_we = 1'b0; m_wa = '0; m_wd = '0; m_busy = '0;
        reset = 1'b1; wb_hold = 1'b0; fwd_addr = '0;
        idle_in();

        tbl[0]  = mk(0,0,0,      1,3,16'hBEEF, 0,0, 0,1, 0,0,0,          16'h0000);
        tbl[1]  = mk(0,0,0,      0,0,0,        0,0, 1,1, 1,3,16'hBEEF,   16'h0000);
        tbl[2]  = mk(0,0,0,      0,0,0,        0,0, 1,1, 0,3,16'hBEEF,   16'h0000);
        tbl[3]  = mk(1,5,16'h1111, 1,6,16'h2222, 0,0, 0,1, 0,3,16'hBEEF, 16'h0000);
        tbl[4]  = mk(1,5,16'h1111, 0,0,0,      0,0, 1,1, 1,6,16'h2222,   16'h0000);
        tbl[5]  = mk(0,0,0,      0,0,0,        0,0, 1,1, 1,5,16'h1111,   16'h0000);
        tbl[6]  = mk(0,0,0,      0,0,0,        0,0, 1,1, 0,5,16'h1111,   16'h0000);
        tbl[7]  = mk(0,0,0,      0,0,0,        1,7, 1,1, 0,5,16'h1111,   16'h0080);
        tbl[8]  = mk(0,0,0,      1,7,16'h7777, 0,0, 0,1, 0,5,16'h1111,   16'h0080);
        tbl[9]  = mk(0,0,0,      0,0,0,        0,0, 1,1, 1,7,16'h7777,   16'h0080);
        tbl[10] = mk(0,0,0,      0,0,0,        0,0, 1,1, 0,7,16'h7777,   16'h0000);
        tbl[11] = mk(0,0,0,      0,0,0,        1,7, 1,1, 0,7,16'h7777,   16'h0080);
        tbl[12] = mk(0,0,0,      1,7,16'h1234, 0,0, 0,1, 0,7,16'h7777,   16'h0080);
        tbl[13] = mk(0,0,0,      0,0,0,        0,0, 1,1, 1,7,16'h1234,   16'h0080);
        tbl[14] = mk(0,0,0,      0,0,0,        1,7, 1,1, 0,7,16'h1234,   16'h0080);
        tbl[15] = mk(0,0,0,      0,0,0,        0,0, 1,1, 0,7,16'h1234,   16'h0080);

        apply();
        apply();
        reset = 1'b0;

        for (int i = 0; i < 16; i++) begin
            set_in(tbl[i].av, tbl[i].aa, tbl[i].ad, tbl[i].mv, tbl[i].ma, tbl[i].md,
                   tbl[i].iv, tbl[i].ia);
            pre_check();
            chk($sformatf("vec%0d_alu_ready", i), bus.alu_ready, tbl[i].x_ar);
            chk($sformatf("vec%0d_mem_ready", i), bus.mem_ready, tbl[i].x_mr);
            tick();
            chk($sformatf("vec%0d_we", i), bus.write_enable, tbl[i].x_we);
            chk($sformatf("vec%0d_waddr", i), bus.write_addr, tbl[i].x_wa);
            chk($sformatf("vec%0d_wdata", i), bus.write_data, tbl[i].x_wd);
            chk($sformatf("vec%0d_busy", i), busy, tbl[i].x_busy);
        end

        // Fill under hold, then release while a fifth result is waiting.
        wb_hold = 1'b1;
        for (int k = 0; k < 4; k++) begin
            set_in(1'b1, AW'(8 + k), DW'(16'hA000 + k), 1'b0, '0, '0, 1'b0, '0);
            pre_check();
            chk("hold_push_ready", bus.alu_ready, 1'b1);
            tick();
        end
        set_in(1'b1, 4'd12, 16'hA004, 1'b0, '0, '0, 1'b0, '0);
        pre_check();
        chk("full_alu_ready", bus.alu_ready, 1'b0);
        tick();
        wb_hold = 1'b0;
        pre_check();
        chk("full_pop_alu_ready", bus.alu_ready, 1'b1);
        tick();
        chk("drain0_we", bus.write_enable, 1'b1);
        chk("drain0_addr", bus.write_addr, 4'd8);
        idle_in();
        for (int k = 1; k < 5; k++) begin
            apply();
            chk("drain_we", bus.write_enable, 1'b1);
            chk("drain_addr", bus.write_addr, 32'(8 + k));
            chk("drain_data", bus.write_data, 32'(16'hA000 + k));
        end
        apply();
        chk("drained_we", bus.write_enable, 1'b0);

        // Reset while three results are buffered.
        wb_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            set_in(1'b0, '0, '0, 1'b1, AW'(k + 1), DW'(16'hD000 + k), 1'b1, AW'(k + 1));
            apply();
        end
        idle_in();
        wb_hold = 1'b0;
        reset = 1'b1;
        apply();
        chk("rst_we", bus.write_enable, 1'b0);
        chk("rst_busy", busy, 16'h0000);
        reset = 1'b0;
        pre_check();
        chk("rst_alu_ready", bus.alu_ready, 1'b1);
        tick();
        for (int k = 0; k < 5; k++) begin
            apply();
            chk("post_rst_no_write", bus.write_enable, 1'b0);
        end

        // Two pending writes to the same register; youngest must forward.
        wb_hold = 1'b1;
        fwd_addr = 4'd9;
        set_in(1'b1, 4'd9, 16'h0001, 1'b0, '0, '0, 1'b0, '0);
        apply();
        set_in(1'b1, 4'd9, 16'h0002, 1'b0, '0, '0, 1'b0, '0);
        apply();
        idle_in();
        pre_check();
`ifdef WB_FORWARD_EN
        chk("fwd9_hit", fwd_hit, 1'b1);
        chk("fwd9_data", fwd_data, 16'h0002);
`else
        chk("fwd9_hit", fwd_hit, 1'b0);
        chk("fwd9_data", fwd_data, 16'h0000);
`endif
        fwd_addr = 4'd4;
        pre_check();
        chk("fwd4_hit", fwd_hit, 1'b0);
        chk("fwd4_data", fwd_data, 16'h0000);
        tick();
        wb_hold = 1'b0;

        for (int n = 0; n < 400; n++) begin
            reset   = ($urandom_range(0, 49) == 0);
            wb_hold = ($urandom_range(0, 2) == 0);
            set_in($urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
                   $urandom_range(0, 1) == 1, AW'($urandom), DW'($urandom),
                   $urandom_range(0, 2) == 0, AW'($urandom));
            fwd_addr = AW'($urandom);
            apply();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
